// File: rtl/mem_arbiter_pkg.sv
// Shared types for the ibus/dbus memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } arb_owner_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } mem_req_t;

  // Instruction fetches are always 4-byte accesses.
  localparam logic [2:0] MSIZE_W = 3'd2;

  // Which requester currently owns the memory port.
  function automatic arb_owner_t state_owner(input arb_state_t s);
    case (s)
      GNT_I:   return OWN_I;
      GNT_D:   return OWN_D;
      default: return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational priority picker: dbus first unless ibus has been starved.
// Latency: purely combinational.
// Backpressure: none; callers decide when a pick is honoured.
module mem_arb_pick (
  input  logic ireq_valid,
  input  logic dreq_valid,
  input  logic starve_at_limit,
  input  logic exclude_i,
  input  logic exclude_d,
  output logic pick_i,
  output logic pick_d
);

  logic i_live;
  logic d_live;

  // An excluded requester is one whose valid belongs to the transaction now completing.
  always_comb begin
    i_live = ireq_valid && !exclude_i;
    d_live = dreq_valid && !exclude_d;
    pick_d = d_live && !(i_live && starve_at_limit);
    pick_i = i_live && !pick_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between ibus and dbus; dbus priority with ibus starvation guard.
// Latency: request in cycle N -> mreq_valid in N+1; one IDLE bubble between transactions
//          unless MEM_ARB_B2B_EN is defined (then back-to-back grants on completion).
// Backpressure: requests wait (valid held) until granted; grant held until mresp_data_ok.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  output logic        iresp_data_ok,
  output logic [31:0] iresp_data,
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        dresp_data_ok,
  output logic [63:0] dresp_data,
  output logic        mreq_valid,
  output logic [63:0] mreq_addr,
  output logic [2:0]  mreq_size,
  output logic [7:0]  mreq_strobe,
  output logic [63:0] mreq_data,
  input  logic        mresp_data_ok,
  input  logic [63:0] mresp_data,
  output logic        busy
);

`ifdef MEM_ARB_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  arb_state_t    state;
  arb_state_t    state_nxt;
  arb_owner_t    owner;
  mem_req_t      req_q;
  logic [CW-1:0] starve_cnt;
  logic          starve_at_limit;
  logic          excl_i;
  logic          excl_d;
  logic          i_wait;
  logic          pick_i;
  logic          pick_d;
  logic          grant_i;
  logic          grant_d;

  assign owner           = state_owner(state);
  assign starve_at_limit = (starve_cnt == CW'(STARVE_LIMIT));
  // In back-to-back mode the completing owner still has valid high; it must not re-win.
  assign excl_i          = B2B && (owner == OWN_I);
  assign excl_d          = B2B && (owner == OWN_D);
  assign i_wait          = ireq_valid && !excl_i;

  mem_arb_pick u_pick (
    .ireq_valid      (ireq_valid),
    .dreq_valid      (dreq_valid),
    .starve_at_limit (starve_at_limit),
    .exclude_i       (excl_i),
    .exclude_d       (excl_d),
    .pick_i          (pick_i),
    .pick_d          (pick_d)
  );

  assign mreq_addr   = req_q.addr;
  assign mreq_size   = req_q.size;
  assign mreq_strobe = req_q.strobe;
  assign mreq_data   = req_q.data;

  // State register; async reset drops mreq_valid/busy without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, grants and response routing to the current owner only.
  always_comb begin
    state_nxt     = state;
    grant_i       = 1'b0;
    grant_d       = 1'b0;
    mreq_valid    = 1'b0;
    busy          = 1'b0;
    iresp_data_ok = 1'b0;
    dresp_data_ok = 1'b0;
    iresp_data    = '0;
    dresp_data    = '0;
    case (state)
      IDLE: begin
        grant_d = pick_d;
        grant_i = pick_i;
      end
      GNT_I: begin
        mreq_valid = 1'b1;
        busy       = 1'b1;
        iresp_data = req_q.addr[2] ? mresp_data[63:32] : mresp_data[31:0];
        if (mresp_data_ok) begin
          iresp_data_ok = 1'b1;
          state_nxt     = IDLE;
          if (B2B) begin
            grant_d = pick_d;
            grant_i = pick_i;
          end
        end
      end
      GNT_D: begin
        mreq_valid = 1'b1;
        busy       = 1'b1;
        dresp_data = mresp_data;
        if (mresp_data_ok) begin
          dresp_data_ok = 1'b1;
          state_nxt     = IDLE;
          if (B2B) begin
            grant_d = pick_d;
            grant_i = pick_i;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (grant_d)      state_nxt = GNT_D;
    else if (grant_i) state_nxt = GNT_I;
  end

  // Request latch: memory only ever sees the captured request, never live inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q <= '0;
    end else if (grant_d) begin
      req_q <= '{addr: dreq_addr, size: dreq_size, strobe: dreq_strobe, data: dreq_data};
    end else if (grant_i) begin
      req_q <= '{addr: ireq_addr, size: MSIZE_W, strobe: 8'h00, data: 64'h0};
    end
  end

  // Count consecutive dbus wins over a waiting ibus; any other grant resets the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant_d && i_wait) begin
      if (!starve_at_limit) starve_cnt <= starve_cnt + CW'(1);
    end else if (grant_i || grant_d) begin
      starve_cnt <= '0;
    end
  end

`ifndef SYNTHESIS
  // Flag requester/memory protocol violations; the transaction itself is unaffected.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(state == GNT_I && !ireq_valid))
        else $warning("mem_arbiter: ibus dropped valid while granted");
      assert (!(state == GNT_D && !dreq_valid))
        else $warning("mem_arbiter: dbus dropped valid while granted");
      assert (!(state == IDLE && mresp_data_ok))
        else $warning("mem_arbiter: memory data_ok with no transaction outstanding");
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with immediate-assertion checks.
// Latency: n/a.
// Backpressure: bench plays both requesters and the memory.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        mreq_valid;
  logic [63:0] mreq_addr;
  logic [2:0]  mreq_size;
  logic [7:0]  mreq_strobe;
  logic [63:0] mreq_data;
  logic        mresp_data_ok;
  logic [63:0] mresp_data;
  logic        busy;

  int checks;
  int errors;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data),
    .mreq_valid    (mreq_valid),
    .mreq_addr     (mreq_addr),
    .mreq_size     (mreq_size),
    .mreq_strobe   (mreq_strobe),
    .mreq_data     (mreq_data),
    .mresp_data_ok (mresp_data_ok),
    .mresp_data    (mresp_data),
    .busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  logic exp_d   [6];
  int   exp_cnt [6];
  int   exp_gap;

  initial begin
    checks = 0;
    errors = 0;
`ifdef MEM_ARB_B2B_EN
    exp_d   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_cnt = '{1, 0, 0, 0, 0, 0};
    exp_gap = 0;
`else
    exp_d   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_cnt = '{1, 2, 3, 4, 0, 1};
    exp_gap = 1;
`endif

    reset = 1'b1;
    ireq_valid = 1'b0; ireq_addr = '0;
    dreq_valid = 1'b0; dreq_addr = '0; dreq_size = '0; dreq_strobe = '0; dreq_data = '0;
    mresp_data_ok = 1'b0; mresp_data = '0;
    #1;
    chk("rst_mreq_valid", 64'(mreq_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_iok", 64'(iresp_data_ok), 64'd0);
    chk("rst_dok", 64'(dresp_data_ok), 64'd0);
    chk("rst_mreq_addr", mreq_addr, 64'd0);
    chk("rst_mreq_strobe", 64'(mreq_strobe), 64'd0);
    chk("rst_starve", 64'(dut.starve_cnt), 64'd0);
    tick();
    tick();
    reset = 1'b0;

    // Test 1: ibus fetch alone, upper word selected by addr[2].
    ireq_valid = 1'b1; ireq_addr = 64'h8000_0004;
    #1;
    chk("t1_not_yet", 64'(mreq_valid), 64'd0);
    tick();
    chk("t1_mreq_valid", 64'(mreq_valid), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_addr", mreq_addr, 64'h8000_0004);
    chk("t1_size", 64'(mreq_size), 64'd2);
    chk("t1_strobe", 64'(mreq_strobe), 64'd0);
    chk("t1_data", mreq_data, 64'd0);
    tick();
    chk("t1_still_valid", 64'(mreq_valid), 64'd1);
    ireq_addr = 64'h0;
    tick();
    mresp_data_ok = 1'b1; mresp_data = 64'hAAAA_BBBB_1111_2222;
    #1;
    chk("t1_addr_held", mreq_addr, 64'h8000_0004);
    chk("t1_iok", 64'(iresp_data_ok), 64'd1);
    chk("t1_idata", 64'(iresp_data), 64'hAAAA_BBBB);
    chk("t1_dok", 64'(dresp_data_ok), 64'd0);
    chk("t1_ddata", dresp_data, 64'd0);
    tick();
    mresp_data_ok = 1'b0; ireq_valid = 1'b0;
    #1;
    chk("t1_iok_pulse", 64'(iresp_data_ok), 64'd0);
    chk("t1_idle", 64'(mreq_valid), 64'd0);
    tick();

    // Test 2: simultaneous requests, dbus wins, ibus follows.
    ireq_valid = 1'b1; ireq_addr = 64'h100;
    dreq_valid = 1'b1; dreq_addr = 64'h200; dreq_size = 3'd3;
    dreq_strobe = 8'hFF; dreq_data = 64'h1234;
    tick();
    chk("t2_d_strobe", 64'(mreq_strobe), 64'hFF);
    chk("t2_d_addr", mreq_addr, 64'h200);
    chk("t2_d_data", mreq_data, 64'h1234);
    chk("t2_d_size", 64'(mreq_size), 64'd3);
    chk("t2_starve1", 64'(dut.starve_cnt), 64'd1);
    tick();
    mresp_data_ok = 1'b1; mresp_data = 64'h5555;
    #1;
    chk("t2_dok", 64'(dresp_data_ok), 64'd1);
    chk("t2_ddata", dresp_data, 64'h5555);
    chk("t2_iok", 64'(iresp_data_ok), 64'd0);
    tick();
    mresp_data_ok = 1'b0; dreq_valid = 1'b0;
`ifdef MEM_ARB_B2B_EN
    chk("t2_b2b_grant", 64'(mreq_valid), 64'd1);
`else
    chk("t2_bubble", 64'(mreq_valid), 64'd0);
    tick();
`endif
    chk("t2_i_valid", 64'(mreq_valid), 64'd1);
    chk("t2_i_addr", mreq_addr, 64'h100);
    chk("t2_i_size", 64'(mreq_size), 64'd2);
    chk("t2_i_strobe", 64'(mreq_strobe), 64'd0);
    chk("t2_starve0", 64'(dut.starve_cnt), 64'd0);
    tick();
    mresp_data_ok = 1'b1; mresp_data = 64'hDEAD_BEEF_CAFE_F00D;
    #1;
    chk("t2_iok2", 64'(iresp_data_ok), 64'd1);
    chk("t2_idata_lo", 64'(iresp_data), 64'hCAFE_F00D);
    tick();
    mresp_data_ok = 1'b0; ireq_valid = 1'b0;
    tick();

    // Tests 3/4: ibus held, six dbus requests, memory answers one cycle after grant.
    ireq_valid = 1'b1; ireq_addr = 64'h40;
    dreq_valid = 1'b1; dreq_addr = 64'h500; dreq_size = 3'd3;
    dreq_strobe = 8'h0F; dreq_data = 64'h1;
    for (int g = 0; g < 6; g++) begin
      int n;
      n = 0;
      #1;
      while (!mreq_valid && n < 8) begin
        tick();
        n++;
      end
      chk("t3_grant_seen", 64'(mreq_valid), 64'd1);
      if (g > 0) chk("t4_gap", 64'(n), 64'(exp_gap));
      chk("t3_owner_d", 64'(mreq_strobe == 8'h0F), 64'(exp_d[g]));
      chk("t3_starve", 64'(dut.starve_cnt), 64'(exp_cnt[g]));
      tick();
      mresp_data_ok = 1'b1; mresp_data = 64'hC0DE_0000_0000_0000 | 64'(g);
      if (g == 5) begin
        if (exp_d[g]) ireq_valid = 1'b0;
        else          dreq_valid = 1'b0;
      end
      #1;
      chk("t3_dok", 64'(dresp_data_ok), 64'(exp_d[g]));
      chk("t3_iok", 64'(iresp_data_ok), 64'(!exp_d[g]));
      tick();
      mresp_data_ok = 1'b0;
    end
    ireq_valid = 1'b0; dreq_valid = 1'b0;
    tick();
    chk("t3_end_idle", 64'(mreq_valid), 64'd0);

    // Test 5: async reset while dbus is granted.
    dreq_valid = 1'b1; dreq_addr = 64'h300; dreq_strobe = 8'h01; dreq_data = 64'h5;
    tick();
    chk("t5_granted", 64'(mreq_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_valid_drop", 64'(mreq_valid), 64'd0);
    chk("t5_busy_drop", 64'(busy), 64'd0);
    chk("t5_latch_clr", 64'(mreq_strobe), 64'd0);
    dreq_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    mresp_data_ok = 1'b1; mresp_data = 64'h1;
    #1;
    chk("t5_no_dok", 64'(dresp_data_ok), 64'd0);
    chk("t5_no_iok", 64'(iresp_data_ok), 64'd0);
    tick();
    mresp_data_ok = 1'b0;
    chk("t5_idle", 64'(mreq_valid), 64'd0);

    // Test 6: dbus drops valid mid-grant; latched request must not move.
    dreq_valid = 1'b1; dreq_addr = 64'h400; dreq_size = 3'd3; dreq_strobe = 8'h00; dreq_data = 64'h99;
    tick();
    chk("t6_granted", 64'(mreq_valid), 64'd1);
    chk("t6_starve", 64'(dut.starve_cnt), 64'd0);
    dreq_valid = 1'b0; dreq_addr = 64'hFFF; dreq_data = 64'h0;
    tick();
    chk("t6_held_valid", 64'(mreq_valid), 64'd1);
    chk("t6_held_addr", mreq_addr, 64'h400);
    chk("t6_held_data", mreq_data, 64'h99);
    tick();
    mresp_data_ok = 1'b1; mresp_data = 64'h77;
    #1;
    chk("t6_dok", 64'(dresp_data_ok), 64'd1);
    chk("t6_ddata", dresp_data, 64'h77);
    tick();
    mresp_data_ok = 1'b0;
    chk("t6_idle", 64'(mreq_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
